riscv_irq_arbiter: RTL

RISCV_IRQ_ARBITER -- requirements
Module: riscv_irq_arbiter

---
 rtl/riscv_defines.sv | 23 ++
 rtl/riscv_irq_prio_enc.sv | 30 +++
 rtl/riscv_irq_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/riscv_defines.sv
`default_nettype none
// ============================================================================
// Module   : riscv_defines (package)
// Brief    : Shared constants and types for the interrupt arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_defines;

    localparam int IRQ_ID_W = 5;

    localparam logic [1:0] c_CFG_ADDR_MASK     = 2'd0;
    localparam logic [1:0] c_CFG_ADDR_PEND_SET = 2'd1;
    localparam logic [1:0] c_CFG_ADDR_PEND_CLR = 2'd2;
    localparam logic [1:0] c_CFG_ADDR_SECURE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ACKED = 2'd2
    } irq_state_e;

endpackage
`default_nettype wire

// File: rtl/riscv_irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : riscv_irq_prio_enc
// Brief    : Combinational priority encoder; highest set index wins.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_irq_prio_enc
    import riscv_defines::*;
#(
    parameter int NUM_IRQ = 32
) (
    input  logic [NUM_IRQ-1:0]  i_vec,
    output logic [IRQ_ID_W-1:0] o_id,
    output logic                o_valid
);

    // Ascending scan: later (higher) indices overwrite lower ones.
    always_comb begin
        o_id    = '0;
        o_valid = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (i_vec[i]) begin
                o_id    = IRQ_ID_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/riscv_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : riscv_irq_arbiter
// Brief    : Edge-latched interrupt pending/mask/secure arbiter with a
//            request/acknowledge handshake towards the core.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_irq_arbiter
    import riscv_defines::*;
#(
    parameter int NUM_IRQ = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_IRQ-1:0]  irq_i,
    input  logic                cfg_we_i,
    input  logic [1:0]          cfg_addr_i,
    input  logic [31:0]         cfg_wdata_i,
    output logic [31:0]         cfg_rdata_o,
    output logic                irq_pending_o,
    output logic [IRQ_ID_W-1:0] irq_id_o,
    output logic                irq_sec_o,
    input  logic                irq_ack_i,
    input  logic [IRQ_ID_W-1:0] irq_ack_id_i
);

    logic [NUM_IRQ-1:0]  r_irq_q;
    logic [NUM_IRQ-1:0]  r_pend;
    logic [NUM_IRQ-1:0]  r_mask;
    logic [NUM_IRQ-1:0]  r_secure;

    logic [NUM_IRQ-1:0]  w_edge;
    logic [NUM_IRQ-1:0]  w_wdata;
    logic [NUM_IRQ-1:0]  w_ack_clr;
    logic [NUM_IRQ-1:0]  w_pend_set;
    logic [NUM_IRQ-1:0]  w_pend_clr;
    logic [NUM_IRQ-1:0]  w_pend_nxt;
    logic [NUM_IRQ-1:0]  w_elig;
    logic                w_we_mask;
    logic                w_we_set;
    logic                w_we_clr;
    logic                w_we_sec;

    logic [IRQ_ID_W-1:0] w_win_id;
    logic                w_win_valid;
    logic                w_win_sec;
    logic                w_frozen_live;
    logic [31:0]         w_rdata;

    irq_state_e          r_state;
    irq_state_e          w_state_nxt;
    logic                r_pending;
    logic [IRQ_ID_W-1:0] r_id;
    logic                r_sec;
    logic                w_pending_nxt;
    logic [IRQ_ID_W-1:0] w_id_nxt;
    logic                w_sec_nxt;

    assign w_edge    = irq_i & ~r_irq_q;
    assign w_wdata   = cfg_wdata_i[NUM_IRQ-1:0];
    assign w_we_mask = cfg_we_i && (cfg_addr_i == c_CFG_ADDR_MASK);
    assign w_we_set  = cfg_we_i && (cfg_addr_i == c_CFG_ADDR_PEND_SET);
    assign w_we_clr  = cfg_we_i && (cfg_addr_i == c_CFG_ADDR_PEND_CLR);
    assign w_we_sec  = cfg_we_i && (cfg_addr_i == c_CFG_ADDR_SECURE);

    // Acks naming an id beyond NUM_IRQ decode to no bit at all.
    always_comb begin
        w_ack_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_ack_clr[i] = irq_ack_i && (irq_ack_id_i == IRQ_ID_W'(i));
        end
    end

    assign w_pend_set = w_edge | (w_we_set ? w_wdata : '0);
    assign w_pend_clr = w_ack_clr | (w_we_clr ? w_wdata : '0);
    // Set is applied after clear so a coincident set wins.
    assign w_pend_nxt = (r_pend & ~w_pend_clr) | w_pend_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_q  <= '0;
            r_pend   <= '0;
            r_mask   <= '0;
            r_secure <= '0;
        end else begin
            r_irq_q <= irq_i;
            r_pend  <= w_pend_nxt;
            if (w_we_mask) r_mask   <= w_wdata;
            if (w_we_sec)  r_secure <= w_wdata;
        end
    end

    assign w_elig = r_pend & r_mask;

    riscv_irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .i_vec   (w_elig),
        .o_id    (w_win_id),
        .o_valid (w_win_valid)
    );

    always_comb begin
        w_win_sec     = 1'b0;
        w_frozen_live = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_win_sec     = w_win_sec     | (r_secure[i] && (w_win_id == IRQ_ID_W'(i)));
            w_frozen_live = w_frozen_live | (w_elig[i]   && (r_id     == IRQ_ID_W'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
            r_id      <= '0;
            r_sec     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_id      <= w_id_nxt;
            r_sec     <= w_sec_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = 1'b0;
        w_id_nxt      = r_id;
        w_sec_nxt     = r_sec;
        case (r_state)
            ST_IDLE: begin
                if (w_win_valid) begin
                    w_state_nxt   = ST_REQ;
                    w_pending_nxt = 1'b1;
                    w_id_nxt      = w_win_id;
                    w_sec_nxt     = w_win_sec;
                end
            end
            ST_REQ: begin
                if (irq_ack_i) begin
                    w_state_nxt = ST_ACKED;
                    w_sec_nxt   = 1'b0;
                end else if (!w_frozen_live) begin
                    // Request withdrawn by software (cleared or masked).
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_pending_nxt = 1'b1;
                end
            end
            ST_ACKED: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (cfg_addr_i)
            c_CFG_ADDR_MASK:     w_rdata[NUM_IRQ-1:0] = r_mask;
            c_CFG_ADDR_PEND_SET: w_rdata[NUM_IRQ-1:0] = r_pend;
            c_CFG_ADDR_PEND_CLR: w_rdata[NUM_IRQ-1:0] = r_pend;
            default:             w_rdata[NUM_IRQ-1:0] = r_secure;
        endcase
    end

    assign cfg_rdata_o   = w_rdata;
    assign irq_pending_o = r_pending;
    assign irq_id_o      = r_id;
    assign irq_sec_o     = r_sec;

endmodule
`default_nettype wire
